hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard unit for a 5-stage core.
//            - Operand forwarding select for the Execute stage (M over W)
//            - Load-use stall detection
//            - Multi-cycle unit busy FSM that holds F/D/E while running
//            - Stall / flush generation for F, D and E
//            - Optional saturating stall / flush performance counters
// Config   : define HAZARD_PERF_EN to build the performance counters;
//            otherwise StallCnt / FlushCnt are constant zero.
// Ports    : clk, reset (async, active-low)
//            RAD/UseD       Decode source registers and valid bits
//            RAE/UseE       Execute source registers and valid bits
//            WA3E/M/W, RegWriteE/M/W, MemtoRegE   destination info
//            BranchTakenE, PCSrcW, PCWrPendingF, MulStartE   control
//            ForwardE       2-bit forwarding select per source slot
//            StallF/D/E, FlushD/E, MulBusy, StallCnt, FlushCnt
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int NSRC    = 3,
    parameter int AW      = 4,
    parameter int MUL_LAT = 4,
    parameter int CNTW    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC*AW-1:0]   RAD,
    input  logic [NSRC-1:0]      UseD,
    input  logic [NSRC*AW-1:0]   RAE,
    input  logic [NSRC-1:0]      UseE,
    input  logic [AW-1:0]        WA3E,
    input  logic [AW-1:0]        WA3M,
    input  logic [AW-1:0]        WA3W,
    input  logic                 RegWriteE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 MemtoRegE,
    input  logic                 BranchTakenE,
    input  logic                 PCSrcW,
    input  logic                 PCWrPendingF,
    input  logic                 MulStartE,
    output logic [2*NSRC-1:0]    ForwardE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 MulBusy,
    output logic [CNTW-1:0]      StallCnt,
    output logic [CNTW-1:0]      FlushCnt
);

    localparam int CW = $clog2(MUL_LAT);

    localparam logic [0:0]    S_IDLE = 1'b0;
    localparam logic [0:0]    S_BUSY = 1'b1;

    // Loading MUL_LAT-2 and leaving on cnt==0 gives MUL_LAT-1 busy cycles.
    localparam logic [CW-1:0] c_LOAD = CW'(MUL_LAT - 2);
    localparam logic [CW-1:0] c_ONE  = CW'(1);

    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [NSRC-1:0]  w_ldr_hit;
    logic             w_ldr_stall;
    logic             w_mul_stall;

    // ------------------------------------------------------------------
    // Per-slot forwarding select and load-use match
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_slot
        logic [AW-1:0] w_rae;
        logic [AW-1:0] w_rad;
        assign w_rae = RAE[gi*AW +: AW];
        assign w_rad = RAD[gi*AW +: AW];

        // Memory stage result is younger, so it wins over writeback.
        assign ForwardE[2*gi +: 2] =
            (UseE[gi] && RegWriteM && (w_rae == WA3M)) ? 2'b10 :
            (UseE[gi] && RegWriteW && (w_rae == WA3W)) ? 2'b01 : 2'b00;

        assign w_ldr_hit[gi] = UseD[gi] && (w_rad == WA3E);
    end

    assign w_ldr_stall = MemtoRegE & RegWriteE & (|w_ldr_hit);

    // ------------------------------------------------------------------
    // Multi-cycle unit FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A start on a taken branch belongs to a squashed path.
                    if (MulStartE && !BranchTakenE) begin
                        r_state <= S_BUSY;
                        r_cnt   <= c_LOAD;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_mul_stall = (r_state == S_BUSY);

    // ------------------------------------------------------------------
    // Stall / flush outputs (purely combinational)
    // ------------------------------------------------------------------
    assign MulBusy = w_mul_stall;
    assign StallE  = w_mul_stall;
    assign StallD  = w_ldr_stall | w_mul_stall;
    assign StallF  = w_ldr_stall | w_mul_stall | PCWrPendingF;
    // A held E register must keep its contents, so no flush while busy.
    assign FlushE  = (w_ldr_stall | BranchTakenE) & ~w_mul_stall;
    assign FlushD  = PCWrPendingF | PCSrcW | BranchTakenE;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
    logic [CNTW-1:0] r_stall_cnt;
    logic [CNTW-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (StallF && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
            end
            if ((FlushD | FlushE) && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNTW'(1);
            end
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl with a behavioural model
//            (busy modelled as a remaining-cycle count) compared on every
//            falling clock edge, plus directed literal checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int NSRC    = 3;
    localparam int AW      = 4;
    localparam int MUL_LAT = 4;
    localparam int CNTW    = 4;
    localparam int CMAX    = (1 << CNTW) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NSRC*AW-1:0]   RAD, RAE;
    logic [NSRC-1:0]      UseD, UseE;
    logic [AW-1:0]        WA3E, WA3M, WA3W;
    logic                 RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
    logic                 BranchTakenE, PCSrcW, PCWrPendingF, MulStartE;
    logic [2*NSRC-1:0]    ForwardE;
    logic                 StallF, StallD, StallE, FlushD, FlushE, MulBusy;
    logic [CNTW-1:0]      StallCnt, FlushCnt;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.NSRC(NSRC), .AW(AW), .MUL_LAT(MUL_LAT), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .RAD(RAD), .UseD(UseD), .RAE(RAE), .UseE(UseE),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .PCSrcW(PCSrcW),
        .PCWrPendingF(PCWrPendingF), .MulStartE(MulStartE),
        .ForwardE(ForwardE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .MulBusy(MulBusy),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: m_rem = busy cycles still to come
    // ------------------------------------------------------------------
    int m_rem = 0;
    int m_sc  = 0;
    int m_fc  = 0;

    function automatic logic [2*NSRC-1:0] mdl_fwd();
        logic [2*NSRC-1:0] f = '0;
        for (int i = 0; i < NSRC; i++) begin
            int ra = int'(RAE[i*AW +: AW]);
            if (UseE[i] && RegWriteM && ra == int'(WA3M))      f[2*i +: 2] = 2'b10;
            else if (UseE[i] && RegWriteW && ra == int'(WA3W)) f[2*i +: 2] = 2'b01;
        end
        return f;
    endfunction

    function automatic logic mdl_ldr();
        logic hit = 1'b0;
        for (int i = 0; i < NSRC; i++)
            if (UseD[i] && RAD[i*AW +: AW] == WA3E) hit = 1'b1;
        return MemtoRegE && RegWriteE && hit;
    endfunction

    function automatic logic mdl_busy();
        return m_rem > 0;
    endfunction

    function automatic logic mdl_stallF();
        return mdl_ldr() || mdl_busy() || PCWrPendingF;
    endfunction

    function automatic logic mdl_flushE();
        return (mdl_ldr() || BranchTakenE) && !mdl_busy();
    endfunction

    function automatic logic mdl_flushD();
        return PCWrPendingF || PCSrcW || BranchTakenE;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rem <= 0;
            m_sc  <= 0;
            m_fc  <= 0;
        end else begin
            if (m_rem == 0) begin
                if (MulStartE && !BranchTakenE) m_rem <= MUL_LAT - 1;
            end else begin
                m_rem <= m_rem - 1;
            end
            if (mdl_stallF() && m_sc < CMAX) m_sc <= m_sc + 1;
            if ((mdl_flushD() || mdl_flushE()) && m_fc < CMAX) m_fc <= m_fc + 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("ForwardE", 32'(ForwardE), 32'(mdl_fwd()));
        chk("MulBusy",  32'(MulBusy),  32'(mdl_busy()));
        chk("StallE",   32'(StallE),   32'(mdl_busy()));
        chk("StallD",   32'(StallD),   32'(mdl_ldr() || mdl_busy()));
        chk("StallF",   32'(StallF),   32'(mdl_stallF()));
        chk("FlushE",   32'(FlushE),   32'(mdl_flushE()));
        chk("FlushD",   32'(FlushD),   32'(mdl_flushD()));
`ifdef HAZARD_PERF_EN
        chk("StallCnt", 32'(StallCnt), 32'(m_sc));
        chk("FlushCnt", 32'(FlushCnt), 32'(m_fc));
`else
        chk("StallCnt", 32'(StallCnt), 32'd0);
        chk("FlushCnt", 32'(FlushCnt), 32'd0);
`endif
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic clear_inputs();
        RAD = '0; RAE = '0; UseD = '0; UseE = '0;
        WA3E = '0; WA3M = '0; WA3W = '0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
        BranchTakenE = 1'b0; PCSrcW = 1'b0; PCWrPendingF = 1'b0; MulStartE = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        #2;
        chk("rst_MulBusy",  32'(MulBusy),  32'd0);
        chk("rst_StallE",   32'(StallE),   32'd0);
        chk("rst_StallCnt", 32'(StallCnt), 32'd0);
        chk("rst_FlushCnt", 32'(FlushCnt), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Forwarding priority M over W, then W alone
        RAE = 12'h003; UseE = 3'b001; WA3M = 4'd3; RegWriteM = 1'b1;
        WA3W = 4'd3; RegWriteW = 1'b1;
        #1 chk("fwd_M", 32'(ForwardE), 32'h2);
        RegWriteM = 1'b0;
        #1 chk("fwd_W", 32'(ForwardE), 32'h1);
        tick();
        clear_inputs();

        // Load-use on slot 2
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RAD = 12'h500; UseD = 3'b100;
        #1;
        chk("ldr_StallF", 32'(StallF), 32'd1);
        chk("ldr_StallD", 32'(StallD), 32'd1);
        chk("ldr_FlushE", 32'(FlushE), 32'd1);
        chk("ldr_StallE", 32'(StallE), 32'd0);
        UseD = 3'b000;
        #1;
        chk("noldr_StallF", 32'(StallF), 32'd0);
        chk("noldr_StallD", 32'(StallD), 32'd0);
        chk("noldr_FlushE", 32'(FlushE), 32'd0);
        chk("noldr_StallE", 32'(StallE), 32'd0);
        tick();
        clear_inputs();

        // One-cycle start pulse: busy for exactly MUL_LAT-1 = 3 cycles
        MulStartE = 1'b1;
        #1 chk("mul_pre", 32'(MulBusy), 32'd0);
        tick();
        MulStartE = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("mul_busy",   32'(MulBusy), 32'(k < 3));
            chk("mul_stallF", 32'(StallF),  32'(k < 3));
            chk("mul_stallD", 32'(StallD),  32'(k < 3));
            chk("mul_stallE", 32'(StallE),  32'(k < 3));
            if (k == 1) begin
                // Branch and load-use while busy: E held, D flushed
                BranchTakenE = 1'b1; MemtoRegE = 1'b1; RegWriteE = 1'b1;
                WA3E = 4'd7; RAD = 12'h007; UseD = 3'b001;
                #1;
                chk("busy_FlushE", 32'(FlushE), 32'd0);
                chk("busy_FlushD", 32'(FlushD), 32'd1);
                MulStartE = 1'b1;
            end
            tick();
            clear_inputs();
        end

        // Start together with a taken branch is dropped
        MulStartE = 1'b1; BranchTakenE = 1'b1;
        tick();
        clear_inputs();
        chk("brstart_idle", 32'(MulBusy), 32'd0);

        // Asynchronous reset during the second busy cycle
        MulStartE = 1'b1;
        tick();
        MulStartE = 1'b0;
        tick();
        chk("busy2", 32'(MulBusy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_MulBusy", 32'(MulBusy), 32'd0);
        chk("arst_StallE",  32'(StallE),  32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_busy",   32'(MulBusy), 32'd0);
        chk("post_rst_stallF", 32'(StallF),  32'd0);

        // Counter saturation: StallF held 20 cycles
        reset = 1'b0;
        tick();
        reset = 1'b1;
        PCWrPendingF = 1'b1;
        repeat (20) tick();
`ifdef HAZARD_PERF_EN
        chk("sat_StallCnt", 32'(StallCnt), 32'd15);
        chk("sat_FlushCnt", 32'(FlushCnt), 32'd15);
`else
        chk("off_StallCnt", 32'(StallCnt), 32'd0);
        chk("off_FlushCnt", 32'(FlushCnt), 32'd0);
`endif
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;

        // Randomized traffic; small register range to force matches
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NSRC; i++) begin
                RAD[i*AW +: AW] = AW'($urandom_range(0, 3));
                RAE[i*AW +: AW] = AW'($urandom_range(0, 3));
            end
            UseD = NSRC'($urandom);
            UseE = NSRC'($urandom);
            WA3E = AW'($urandom_range(0, 3));
            WA3M = AW'($urandom_range(0, 3));
            WA3W = AW'($urandom_range(0, 3));
            RegWriteE = 1'($urandom);
            RegWriteM = 1'($urandom);
            RegWriteW = 1'($urandom);
            MemtoRegE = ($urandom_range(0, 2) == 0);
            BranchTakenE = ($urandom_range(0, 5) == 0);
            PCSrcW = ($urandom_range(0, 7) == 0);
            PCWrPendingF = ($urandom_range(0, 7) == 0);
            MulStartE = ($urandom_range(0, 4) == 0);
            if (n == 300) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            tick();
        end

        clear_inputs();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
